mul_issue_ctrl: RTL and testbench
=================================

// Module: mul_issue_ctrl
// PURPOSE
//  Issue/writeback controller for the shift-add multiplier functional unit. Accepts one RV32M
//  MUL-class op from the multiply reservation station and drives the multiplier's start/operand
//  interface. It waits for done, selects the low or high product half, and acknowledges the
//  multiplier (result_taken). The result is then held for CDB arbitration until granted.
//  Tracks the op's branch tag, so speculative ops are squashed on a matching flush.
// PARAMETERS
//  XLEN      32  operand/result width; multiplier instantiated with OPERAND_WIDTH=XLEN
//  ROB_IDX_W 5   width of destination ROB index
// PORTS
//  clk              in   1        clock
//  rst              in   1        reset, synchronous, active-high
//  issue_valid      in   1        RS presents an op
//  issue_ready      out  1        controller can accept (state IDLE)
//  issue_funct3     in   3        000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
//  issue_rs1_v      in   XLEN     operand a
//  issue_rs2_v      in   XLEN     operand b
//  issue_rob_idx    in   ROB_IDX_W destination ROB index
//  issue_br_tag     in   branch_tag_t speculation tag of op
//  flush            in   1        branch-mispredict flush strobe
//  flush_tag        in   branch_tag_t tag being flushed
//  mul_start        out  1        start to multiplier
//  mul_type         out  2        0 u*u, 1 s*s, 2 s*u
//  mul_a, mul_b     out  XLEN     operands to multiplier
//  mul_br_tag       out  branch_tag_t tag to multiplier
//  mul_p            in   2*XLEN   product from multiplier
//  mul_done         in   1        multiplier DONE state
//  mul_result_taken out  1        acknowledge; multiplier returns to IDLE next cycle
//  cdb_req          out  1        result valid, requesting CDB
//  cdb_gnt          in   1        CDB grant
//  cdb_data         out  XLEN     selected result
//  cdb_rob_idx      out  ROB_IDX_W ROB index of result
// BEHAVIOUR
//  - Reset: state IDLE; issue_ready=1; mul_start, mul_result_taken, cdb_req = 0;
//    registered op fields and result = 0.
//  - Flush match (own tag T vs flush_tag F) when flush=1 and either:
//    T.sign==F.sign and (T.tag&F.tag)==F.tag; or T.sign!=F.sign and (T.tag&F.tag)==T.tag.
//  - States: IDLE -> LAUNCH -> WAIT -> WB -> IDLE.
//  - IDLE: issue_ready=1. On issue_valid, latch all fields.
//      * Incoming op's tag flush-matches in the same cycle: drop it, stay IDLE.
//      * Otherwise go to LAUNCH.
//  - mul_type mapping: MUL, MULH -> 1; MULHSU -> 2; MULHU -> 0.
//  - LAUNCH: mul_start=1 only when flush=0; then -> WAIT.
//      * Own flush match -> IDLE, no start.
//      * Non-matching flush: hold start low, retry next cycle.
//  - WAIT: mul_start=0.
//      * Own flush match -> IDLE; the multiplier self-squashes on the same tag.
//      * Else on mul_done: capture result, pulse mul_result_taken=1 for that single cycle,
//        go to WB.
//      * Result selection: MUL takes mul_p[XLEN-1:0]; the others take mul_p[2*XLEN-1:XLEN].
//  - WB: cdb_req=1; cdb_data and cdb_rob_idx stable.
//      * cdb_gnt -> IDLE next cycle.
//      * Own flush match -> IDLE; cdb_req forced 0 combinationally that cycle, even if
//        cdb_gnt=1.
//  - Latency: issue accept at cycle N, mul_start at N+1, done >= N+66; cdb_req the cycle after
//    done. No pipelining: one op in flight; issue_ready=0 outside IDLE.
//  - Flush and mul_done in the same cycle with own match: flush wins, mul_result_taken still
//    pulsed (to free the multiplier), no WB.
//  - rst mid-op: immediate return to IDLE, nothing written back; the multiplier shares rst.
// TESTING
//  - MUL 7*6 -> cdb_data=0x0000002A, correct rob_idx; mul_result_taken pulses exactly once.
//  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000;
//    MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
//  - Flush matching op tag during WAIT (cycle 20) -> IDLE, no cdb_req.
//    Next op 3*5 -> 0x0000000F.
//  - Non-matching flush during LAUNCH -> start delayed one cycle; result still correct.
//  - cdb_gnt withheld 10 cycles in WB -> cdb_req/data stable; grant -> IDLE, issue_ready=1.
//  - rst asserted in WAIT -> all outputs at reset values next cycle; no writeback ever seen.

Source files
------------

// File: rtl/mul_issue_ctrl_if.sv
// Branch-tag type plus the issue/multiplier/CDB port bundle for mul_issue_ctrl.
// slave = controller side, master = reservation station / multiplier / CDB side.
package mul_issue_ctrl_pkg;
  localparam int unsigned TAG_W = 4;

  typedef struct packed {
    logic             sign;
    logic [TAG_W-1:0] tag;
  } branch_tag_t;

  // True when an op tagged t is killed by a flush of tag f
  function automatic logic flush_match(branch_tag_t t, branch_tag_t f);
    if (t.sign == f.sign) return ((t.tag & f.tag) == f.tag);
    else                  return ((t.tag & f.tag) == t.tag);
  endfunction
endpackage

interface mul_issue_ctrl_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ROB_IDX_W = 5
);
  import mul_issue_ctrl_pkg::*;

  logic                 issue_valid;
  logic                 issue_ready;
  logic [2:0]           issue_funct3;
  logic [XLEN-1:0]      issue_rs1_v;
  logic [XLEN-1:0]      issue_rs2_v;
  logic [ROB_IDX_W-1:0] issue_rob_idx;
  branch_tag_t          issue_br_tag;
  logic                 flush;
  branch_tag_t          flush_tag;
  logic                 mul_start;
  logic [1:0]           mul_type;
  logic [XLEN-1:0]      mul_a;
  logic [XLEN-1:0]      mul_b;
  branch_tag_t          mul_br_tag;
  logic [2*XLEN-1:0]    mul_p;
  logic                 mul_done;
  logic                 mul_result_taken;
  logic                 cdb_req;
  logic                 cdb_gnt;
  logic [XLEN-1:0]      cdb_data;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;

  modport slave (
    input  issue_valid, issue_funct3, issue_rs1_v, issue_rs2_v, issue_rob_idx, issue_br_tag,
    input  flush, flush_tag, mul_p, mul_done, cdb_gnt,
    output issue_ready, mul_start, mul_type, mul_a, mul_b, mul_br_tag, mul_result_taken,
    output cdb_req, cdb_data, cdb_rob_idx
  );

  modport master (
    output issue_valid, issue_funct3, issue_rs1_v, issue_rs2_v, issue_rob_idx, issue_br_tag,
    output flush, flush_tag, mul_p, mul_done, cdb_gnt,
    input  issue_ready, mul_start, mul_type, mul_a, mul_b, mul_br_tag, mul_result_taken,
    input  cdb_req, cdb_data, cdb_rob_idx
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback controller for the shift-add multiplier: one RV32M MUL-class op in flight,
// launch, wait for done, pick product half, hold for CDB grant; squashed by matching flush.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ROB_IDX_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  mul_issue_ctrl_if.slave bus
);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_WB
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [2:0]           r_funct3;
  logic [XLEN-1:0]      r_a;
  logic [XLEN-1:0]      r_b;
  logic [ROB_IDX_W-1:0] r_rob_idx;
  branch_tag_t          r_br_tag;
  logic [XLEN-1:0]      r_result;

  logic            w_own_flush;
  logic            w_in_flush;
  logic            w_issue_ready;
  logic            w_mul_start;
  logic            w_result_taken;
  logic            w_cdb_req;
  logic            w_capture;
  logic [1:0]      w_mul_type;
  logic [XLEN-1:0] w_sel;

  assign w_own_flush = bus.flush && flush_match(r_br_tag, bus.flush_tag);
  assign w_in_flush  = bus.flush && flush_match(bus.issue_br_tag, bus.flush_tag);
  assign w_sel       = (r_funct3 == F3_MUL) ? bus.mul_p[XLEN-1:0] : bus.mul_p[2*XLEN-1:XLEN];
  assign w_capture   = (r_state == S_WAIT) && bus.mul_done && !w_own_flush;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Op fields are latched on any IDLE issue; a same-cycle flush only suppresses the launch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rob_idx <= '0;
      r_br_tag  <= '0;
      r_result  <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.issue_valid) begin
        r_funct3  <= bus.issue_funct3;
        r_a       <= bus.issue_rs1_v;
        r_b       <= bus.issue_rs2_v;
        r_rob_idx <= bus.issue_rob_idx;
        r_br_tag  <= bus.issue_br_tag;
      end
      if (w_capture) r_result <= w_sel;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_issue_ready  = 1'b0;
    w_mul_start    = 1'b0;
    w_result_taken = 1'b0;
    w_cdb_req      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_issue_ready = 1'b1;
        if (bus.issue_valid && !w_in_flush) w_next_state = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (w_own_flush) begin
          w_next_state = S_IDLE;
        end else if (!bus.flush) begin
          w_mul_start  = 1'b1;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ack done even when squashed so the multiplier is released
        w_result_taken = bus.mul_done;
        if (w_own_flush)       w_next_state = S_IDLE;
        else if (bus.mul_done) w_next_state = S_WB;
      end
      S_WB: begin
        if (w_own_flush) begin
          w_next_state = S_IDLE;
        end else begin
          w_cdb_req = 1'b1;
          if (bus.cdb_gnt) w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase

    unique case (r_funct3)
      F3_MULHSU: w_mul_type = 2'd2;
      F3_MULHU:  w_mul_type = 2'd0;
      default:   w_mul_type = 2'd1;
    endcase
  end

  assign bus.issue_ready      = w_issue_ready;
  assign bus.mul_start        = w_mul_start;
  assign bus.mul_type         = w_mul_type;
  assign bus.mul_a            = r_a;
  assign bus.mul_b            = r_b;
  assign bus.mul_br_tag       = r_br_tag;
  assign bus.mul_result_taken = w_result_taken;
  assign bus.cdb_req          = w_cdb_req;
  assign bus.cdb_data         = r_result;
  assign bus.cdb_rob_idx      = r_rob_idx;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural 65-cycle multiplier model.
module tb_mul_issue_ctrl;
  import mul_issue_ctrl_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef struct {
    logic [XLEN-1:0] data;
    logic [RW-1:0]   rob;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n_taken;
  int   n_req;
  exp_t sb[$];

  mul_issue_ctrl_if #(.XLEN(XLEN), .ROB_IDX_W(RW)) bus ();

  mul_issue_ctrl #(.XLEN(XLEN), .ROB_IDX_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic tb_match(branch_tag_t t, branch_tag_t f);
    logic [TAG_W-1:0] x;
    x = t.tag & f.tag;
    return (t.sign == f.sign) ? (x == f.tag) : (x == t.tag);
  endfunction

  function automatic logic [XLEN-1:0] ref_mul(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [63:0] ea, eb, p;
    ea = (f3 == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (f3 == 3'b010 || f3 == 3'b011) ? {32'b0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier model: done 65 cycles after start, held until acknowledged
  logic        m_busy, m_done;
  logic [6:0]  m_cnt;
  logic [63:0] m_p;
  branch_tag_t m_tag;
  logic [63:0] w_ea, w_eb;

  assign w_ea = (bus.mul_type == 2'd0) ? {32'b0, bus.mul_a} : {{32{bus.mul_a[31]}}, bus.mul_a};
  assign w_eb = (bus.mul_type == 2'd1) ? {{32{bus.mul_b[31]}}, bus.mul_b} : {32'b0, bus.mul_b};
  assign bus.mul_p    = m_p;
  assign bus.mul_done = m_done;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= '0;
      m_p    <= '0;
      m_tag  <= '0;
    end else if (m_done) begin
      if (bus.mul_result_taken) m_done <= 1'b0;
    end else if (m_busy) begin
      if (bus.flush && tb_match(m_tag, bus.flush_tag)) m_busy <= 1'b0;
      else if (m_cnt == 7'd0) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else m_cnt <= m_cnt - 7'd1;
    end else if (bus.mul_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 7'd63;
      m_p    <= w_ea * w_eb;
      m_tag  <= bus.mul_br_tag;
    end
  end

  // Writeback monitor: pops the scoreboard on every granted CDB request
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mul_result_taken) n_taken++;
      if (bus.cdb_req) n_req++;
      if (bus.cdb_req && bus.cdb_gnt) begin
        check("wb_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("cdb_data", 64'(bus.cdb_data), 64'(e.data));
          check("cdb_rob_idx", 64'(bus.cdb_rob_idx), 64'(e.rob));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [RW-1:0] rob, input branch_tag_t tag, input bit expect_wb);
    int i;
    exp_t e;
    i = 0;
    @(negedge clk);
    while (!bus.issue_ready && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("issue_ready_wait", 64'(bus.issue_ready), 64'd1);
    bus.issue_valid   = 1'b1;
    bus.issue_funct3  = f3;
    bus.issue_rs1_v   = a;
    bus.issue_rs2_v   = b;
    bus.issue_rob_idx = rob;
    bus.issue_br_tag  = tag;
    if (expect_wb) begin
      e.data = ref_mul(f3, a, b);
      e.rob  = rob;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    @(negedge clk);
    while ((!bus.issue_ready || sb.size() != 0) && i < 400) begin
      @(negedge clk);
      i++;
    end
    check("drain_sb", 64'(sb.size()), 64'd0);
    check("drain_ready", 64'(bus.issue_ready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_issue_ready"}, 64'(bus.issue_ready), 64'd1);
    check({pfx, "_mul_start"}, 64'(bus.mul_start), 64'd0);
    check({pfx, "_result_taken"}, 64'(bus.mul_result_taken), 64'd0);
    check({pfx, "_cdb_req"}, 64'(bus.cdb_req), 64'd0);
    check({pfx, "_cdb_data"}, 64'(bus.cdb_data), 64'd0);
    check({pfx, "_cdb_rob_idx"}, 64'(bus.cdb_rob_idx), 64'd0);
    check({pfx, "_mul_a"}, 64'(bus.mul_a), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1);
  end

  initial begin
    branch_tag_t t_a, t_b, t_c;
    int snap;
    n_checks = 0; n_errors = 0; n_taken = 0; n_req = 0;
    t_a = '{sign: 1'b0, tag: 4'b0010};
    t_b = '{sign: 1'b0, tag: 4'b0100};
    t_c = '{sign: 1'b1, tag: 4'b0001};
    rst = 1'b1;
    bus.issue_valid = 1'b0; bus.issue_funct3 = '0; bus.issue_rs1_v = '0; bus.issue_rs2_v = '0;
    bus.issue_rob_idx = '0; bus.issue_br_tag = '0; bus.flush = 1'b0; bus.flush_tag = '0;
    bus.cdb_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    snap = n_taken;
    issue(3'b000, 32'd7, 32'd6, 5'd3, t_a, 1'b1);
    wait_idle();
    check("mul_taken_once", 64'(n_taken - snap), 64'd1);

    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, t_a, 1'b1);
    wait_idle();
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, t_b, 1'b1);
    wait_idle();
    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7, t_c, 1'b1);
    wait_idle();

    // Matching flush 20 cycles after accept lands in WAIT
    snap = n_req;
    issue(3'b000, 32'd11, 32'd13, 5'd8, t_a, 1'b0);
    repeat (19) @(posedge clk);
    #1 bus.flush = 1'b1; bus.flush_tag = t_a;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("wait_flush_idle", 64'(bus.issue_ready), 64'd1);
    repeat (100) @(negedge clk);
    check("wait_flush_no_req", 64'(n_req - snap), 64'd0);
    issue(3'b000, 32'd3, 32'd5, 5'd9, t_a, 1'b1);
    wait_idle();

    // Incoming op flushed in its issue cycle is dropped
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_funct3 = 3'b000; bus.issue_rs1_v = 32'd2;
    bus.issue_rs2_v = 32'd2; bus.issue_rob_idx = 5'd10; bus.issue_br_tag = t_a;
    bus.flush = 1'b1; bus.flush_tag = t_a;
    @(posedge clk);
    #1 bus.issue_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("idle_drop_ready", 64'(bus.issue_ready), 64'd1);
    check("idle_drop_start", 64'(bus.mul_start), 64'd0);

    // Non-matching flush in LAUNCH delays start by one cycle
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd11, t_c, 1'b1);
    bus.flush = 1'b1; bus.flush_tag = '{sign: 1'b1, tag: 4'b0100};
    @(negedge clk);
    check("launch_hold_start", 64'(bus.mul_start), 64'd0);
    check("launch_mul_type", 64'(bus.mul_type), 64'd1);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("launch_retry_start", 64'(bus.mul_start), 64'd1);
    check("launch_mul_a", 64'(bus.mul_a), 64'h8000_0000);
    wait_idle();

    // Grant withheld: request and payload must hold steady
    bus.cdb_gnt = 1'b0;
    issue(3'b000, 32'd100, 32'd200, 5'd17, t_b, 1'b1);
    begin
      int i;
      i = 0;
      while (!bus.cdb_req && i < 200) begin
        @(negedge clk);
        i++;
      end
    end
    check("wb_req_seen", 64'(bus.cdb_req), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("wb_hold_req", 64'(bus.cdb_req), 64'd1);
      check("wb_hold_data", 64'(bus.cdb_data), 64'd20000);
      check("wb_hold_rob", 64'(bus.cdb_rob_idx), 64'd17);
    end
    @(posedge clk);
    #1 bus.cdb_gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_gnt_ready", 64'(bus.issue_ready), 64'd1);
    check("post_gnt_req", 64'(bus.cdb_req), 64'd0);
    check("post_gnt_sb", 64'(sb.size()), 64'd0);

    // Reset in WAIT abandons the op
    snap = n_req;
    issue(3'b011, 32'h1234, 32'h5678, 5'd4, t_b, 1'b0);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midop_rst");
    repeat (120) @(negedge clk);
    check("midop_rst_no_req", 64'(n_req - snap), 64'd0);
    check("final_sb", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
